fetch_ifid_stage: RTL and testbench
===================================

Name: fetch_ifid_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and issues instruction-memory fetches over a req/ack handshake with variable latency.
- Presents {PC+4, instruction, valid} to ID.
- Consumes the hazard unit's PC/IF-ID stall and the branch unit's flush/redirect.

Parameters:
ADDR_W, 32, PC and fetch address width
INST_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  begin fetching; sampled only in IDLE
stall_i  in  1  hazard stall; freezes PC advance and IF/ID
flush_i  in  1  squash IF/ID contents (branch taken in ID)
redirect_i  in  1  load new PC; discard any in-flight fetch
redirect_pc_i  in  ADDR_W  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address; stable while imem_req_o=1
imem_ack_i  in  1  data valid this cycle; may be asserted in the first req cycle
imem_data_i  in  INST_W  fetched instruction
pc_o  out  ADDR_W  current fetch PC
ifid_pc_o  out  ADDR_W  PC+4 of the instruction in ID
ifid_inst_o  out  INST_W  instruction in ID; 0 (nop) when invalid
ifid_valid_o  out  1  ID holds a real instruction
busy_o  out  1  fetch outstanding (state REQ with no ack yet)

Behaviour:
- Reset (rst_i=0, async): pc=RESET_PC, state=IDLE, pend_redir=0, hold buffer=0, all outputs 0 except pc_o=RESET_PC.
- States:
  - IDLE: req=0. start_i=1 -> REQ.
  - REQ: req=1, addr=pc.
  - HOLD: req=0; fetched word buffered because ID is stalled.
- IF/ID register is updated only at edges where stall_i=0 or flush_i=1.
- REQ, edge with ack=1:
  - Discard condition: pend_redir=1 or redirect_i=1. Data is discarded; pc <= target (redirect_pc_i if redirect_i, else latched target); pend_redir <= 0; stay REQ; IF/ID gets a bubble unless stalled.
  - Else if stall_i=0: IF/ID <= {pc+4, data, 1}; pc <= pc+4; stay REQ (back-to-back fetch, 1 instr/cycle at zero wait).
  - Else: buffer <= data; pc <= pc+4; -> HOLD; IF/ID unchanged.
- REQ, edge with ack=0:
  - Address held.
  - redirect_i=1 sets pend_redir and latches redirect_pc_i; a later redirect overwrites the latched target.
  - stall_i=0: IF/ID <= bubble {0,0,0}; stall_i=1: IF/ID held.
- HOLD:
  - redirect_i=1: discard buffer; pc <= redirect_pc_i; -> REQ.
  - Else if stall_i=0: IF/ID <= {pc, buffer, 1} (pc already advanced, equals PC+4 of buffered instr); -> REQ.
  - Else stay.
- flush_i=1: IF/ID <= {0,0,0} at that edge regardless of stall_i or ack; flush has priority over any load. The fetch side is governed independently by redirect_i.
- stall_i with redirect_i in the same cycle: the redirect is never lost; it takes effect per the rules above.
- Address arithmetic: pc+4 wraps modulo 2^ADDR_W. pc[1:0] is never checked.
- Reset mid-request: req drops immediately (async); any late ack after reset release, while in IDLE, is ignored.
- pc_o = pc register; busy_o = (state==REQ) & ~imem_ack_i.

Decomposition:
- Shared package cpu_pkg: ADDR_W/INST_W defaults, NOP_INST=32'h0, fetch-state enum {IDLE, REQ, HOLD}.
- One sub-module, ifid_reg: the IF/ID register, with load / bubble / hold / flush controls and flush priority.
- Fetch FSM, PC and redirect bookkeeping live in the top.

Test Plan:
1. Reset, then start_i=1 with imem_ack_i tied 1 and stall/flush/redirect=0 -> addr 0,4,8 on consecutive cycles; ifid_pc_o 4,8,12 one cycle later, valid=1.
2. Zero-wait stream, stall_i=1 for one cycle at the fetch with addr=8 -> HOLD; buffered instr appears in ID next cycle with ifid_pc_o=12; no instruction is duplicated or dropped.
3. Ack latency 3 cycles, stall_i=0 -> addr held 3 cycles, busy_o=1 for 2 cycles, IF/ID bubbles (valid=0, inst=0) between real instrs.
4. redirect_i with redirect_pc_i=0x100 while a fetch is pending, ack 2 cycles later -> returned data discarded, next addr=0x100, next valid ifid_pc_o=0x104.
5. flush_i=1 together with stall_i=1 while IF/ID holds a valid instr -> IF/ID cleared to {0,0,0} at that edge.
6. rst_i low mid-request with an ack arriving during reset -> req=0 immediately; after release pc_o=RESET_PC, IDLE, no spurious IF/ID load.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline slice: default widths, the nop
// encoding and the instruction-fetch state type.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_INST_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Flush beats load, load beats bubble, and with
// no control asserted the contents are held.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int INST_W = CPU_INST_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  // Pipeline register update with flush priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o    <= {ADDR_W{1'b0}};
      inst_o  <= INST_W'(NOP_INST);
      valid_o <= 1'b0;
    end else if (flush_i || (bubble_i && !load_i)) begin
      pc_o    <= {ADDR_W{1'b0}};
      inst_o  <= INST_W'(NOP_INST);
      valid_o <= 1'b0;
    end else if (load_i) begin
      pc_o    <= pc_i;
      inst_o  <= inst_i;
      valid_o <= 1'b1;
    end else begin
      pc_o    <= pc_o;
      inst_o  <= inst_o;
      valid_o <= valid_o;
    end
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction-memory req/ack
// fetch FSM, redirect bookkeeping and the IF/ID register feeding ID.
module fetch_ifid_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = CPU_ADDR_W,
  parameter int              INST_W   = CPU_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic              ifid_valid_o,
  output logic              busy_o
);

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] tgt_r, tgt_s;
  logic              pend_r, pend_s;
  logic [INST_W-1:0] buf_r, buf_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              load_s, bubble_s;
  logic [ADDR_W-1:0] ld_pc_s;
  logic [INST_W-1:0] ld_inst_s;

  assign pc_inc_s = pc_r + ADDR_W'(4);

  // Next-state, PC and IF/ID control decode for the fetch FSM.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    tgt_s     = tgt_r;
    pend_s    = pend_r;
    buf_s     = buf_r;
    load_s    = 1'b0;
    bubble_s  = 1'b0;
    ld_pc_s   = pc_inc_s;
    ld_inst_s = buf_r;
    case (state_r)
      IDLE: begin
        bubble_s = ~stall_i;
        if (start_i) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          // A redirect seen during or at the end of the fetch wins over its data.
          if (pend_r || redirect_i) begin
            pc_s     = redirect_i ? redirect_pc_i : tgt_r;
            pend_s   = 1'b0;
            bubble_s = ~stall_i;
          end else if (!stall_i) begin
            load_s    = 1'b1;
            ld_pc_s   = pc_inc_s;
            ld_inst_s = imem_data_i;
            pc_s      = pc_inc_s;
          end else begin
            buf_s   = imem_data_i;
            pc_s    = pc_inc_s;
            state_s = HOLD;
          end
        end else begin
          bubble_s = ~stall_i;
          if (redirect_i) begin
            pend_s = 1'b1;
            tgt_s  = redirect_pc_i;
          end else begin
            pend_s = pend_r;
            tgt_s  = tgt_r;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          buf_s    = {INST_W{1'b0}};
          pc_s     = redirect_pc_i;
          state_s  = REQ;
          bubble_s = ~stall_i;
        end else if (!stall_i) begin
          // pc already advanced past the buffered word, so it is its PC+4.
          load_s    = 1'b1;
          ld_pc_s   = pc_r;
          ld_inst_s = buf_r;
          state_s   = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Fetch-side state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= {ADDR_W{1'b0}};
      pend_r  <= 1'b0;
      buf_r   <= {INST_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      tgt_r   <= tgt_s;
      pend_r  <= pend_s;
      buf_r   <= buf_s;
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_ifid_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .load_i   (load_s),
    .bubble_i (bubble_s),
    .pc_i     (ld_pc_s),
    .inst_i   (ld_inst_s),
    .pc_o     (ifid_pc_o),
    .inst_o   (ifid_inst_o),
    .valid_o  (ifid_valid_o)
  );

  assign imem_req_o  = (state_r == REQ);
  assign imem_addr_o = pc_r;
  assign pc_o        = pc_r;
  assign busy_o      = (state_r == REQ) & ~imem_ack_i;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Randomized bench for fetch_ifid_stage: a memory responder with random
// latency and a transaction-level reference model of fetch and IF/ID.
module tb_fetch_ifid_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o, ifid_pc_o, ifid_inst_o;
  logic        ifid_valid_o, busy_o;

  fetch_ifid_stage #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .pc_o          (pc_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_inst_o   (ifid_inst_o),
    .ifid_valid_o  (ifid_valid_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetch engine status plus the word ID should hold.
  bit          m_active, m_holding, m_pend;
  logic [31:0] m_pc, m_tgt, m_buf;
  logic [31:0] e_pc, e_inst;
  bit          e_valid;
  int          wait_cnt, cur_lat, lat_max;
  bit          late_ack;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_holding = 1'b0; m_pend = 1'b0;
    m_pc = 32'h0000_0000; m_tgt = 32'h0; m_buf = 32'h0;
    e_pc = 32'h0; e_inst = 32'h0; e_valid = 1'b0;
    wait_cnt = 0; cur_lat = 0;
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    bit          deliver;
    logic [31:0] d_pc, d_inst;
    bit          fetching;
    deliver = 1'b0; d_pc = 32'h0; d_inst = 32'h0;
    fetching = m_active && !m_holding;
    if (m_active && m_holding) begin
      if (!redirect_i && !stall_i) begin
        deliver = 1'b1; d_pc = m_pc; d_inst = m_buf;
      end
    end else if (fetching && imem_ack_i && !(m_pend || redirect_i) && !stall_i) begin
      deliver = 1'b1; d_pc = m_pc + 32'd4; d_inst = imem_data_i;
    end
    if (flush_i) begin
      e_pc = 32'h0; e_inst = 32'h0; e_valid = 1'b0;
    end else if (!stall_i) begin
      e_pc = deliver ? d_pc : 32'h0;
      e_inst = deliver ? d_inst : 32'h0;
      e_valid = deliver;
    end
    if (!m_active) begin
      if (start_i) m_active = 1'b1;
    end else if (m_holding) begin
      if (redirect_i) begin
        m_holding = 1'b0; m_pc = redirect_pc_i;
      end else if (!stall_i) begin
        m_holding = 1'b0;
      end
    end else if (imem_ack_i) begin
      if (m_pend || redirect_i) begin
        m_pc = redirect_i ? redirect_pc_i : m_tgt;
        m_pend = 1'b0;
      end else begin
        if (stall_i) begin
          m_holding = 1'b1; m_buf = imem_data_i;
        end
        m_pc = m_pc + 32'd4;
      end
      wait_cnt = 0;
      cur_lat = $urandom_range(lat_max, 0);
    end else begin
      wait_cnt++;
      if (redirect_i) begin
        m_pend = 1'b1; m_tgt = redirect_pc_i;
      end
    end
  endtask

  task automatic check_outputs();
    bit e_req;
    e_req = m_active && !m_holding;
    check_val("imem_req", {31'b0, imem_req_o}, {31'b0, e_req});
    if (e_req) check_val("imem_addr", imem_addr_o, m_pc);
    check_val("busy", {31'b0, busy_o}, {31'b0, e_req && !imem_ack_i});
    check_val("pc", pc_o, m_pc);
    check_val("ifid_valid", {31'b0, ifid_valid_o}, {31'b0, e_valid});
    check_val("ifid_pc", ifid_pc_o, e_pc);
    check_val("ifid_inst", ifid_inst_o, e_inst);
  endtask

  // One clock: drive inputs at negedge, check state, then step the model.
  task automatic one_cycle(input int p_start, input int p_stall, input int p_flush, input int p_redir);
    int          sel;
    logic [31:0] r;
    @(negedge clk_i);
    start_i    = ($urandom_range(99, 0) < p_start);
    stall_i    = ($urandom_range(99, 0) < p_stall);
    flush_i    = ($urandom_range(99, 0) < p_flush);
    redirect_i = ($urandom_range(99, 0) < p_redir);
    sel = $urandom_range(3, 0);
    r = $urandom;
    redirect_pc_i = (sel == 0) ? 32'h0000_0100 :
                    (sel == 1) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
    imem_ack_i = late_ack || (m_active && !m_holding && (wait_cnt >= cur_lat));
    imem_data_i = (m_active && !m_holding) ? mem_word(m_pc) : $urandom;
    #1;
    check_outputs();
    @(posedge clk_i);
    model_step();
  endtask

  task automatic run_phase(input int cycles, input int lmax, input int p_start,
                           input int p_stall, input int p_flush, input int p_redir);
    lat_max = lmax;
    for (int i = 0; i < cycles; i++) one_cycle(p_start, p_stall, p_flush, p_redir);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
    late_ack = 1'b0; lat_max = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
    rst_i = 1'b1;

    run_phase(6, 0, 100, 0, 0, 0);       // zero-wait stream
    run_phase(40, 0, 100, 30, 0, 0);     // stalls against a zero-wait stream
    run_phase(40, 3, 100, 0, 0, 0);      // multi-cycle ack latency
    run_phase(80, 3, 100, 20, 10, 15);
    run_phase(80, 2, 100, 40, 25, 30);
    run_phase(40, 0, 100, 50, 10, 40);

    // Reset while a fetch is outstanding, with an ack arriving during reset.
    lat_max = 3;
    @(negedge clk_i);
    rst_i = 1'b0; imem_ack_i = 1'b1; imem_data_i = 32'hCAFE_F00D;
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; start_i = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    late_ack = 1'b1;
    one_cycle(0, 0, 0, 0);
    late_ack = 1'b0;
    run_phase(3, 1, 0, 0, 0, 0);
    run_phase(60, 1, 50, 20, 10, 10);

    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
